// File: rtl/icmp_echo_engine.sv
// ICMP echo responder: buffers an Echo Request, verifies its checksum and streams
// back the Echo Reply with recomputed checksum, honouring TX backpressure.
module icmp_echo_engine #(
    parameter int P_MAX_PAYLOAD = 64,
    parameter int P_CNT_W       = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [7:0]         i_icmp_data,
    input  logic [15:0]        i_icmp_len,
    input  logic               i_icmp_last,
    input  logic               i_icmp_valid,
    output logic [7:0]         o_icmp_data,
    output logic [15:0]        o_icmp_len,
    output logic               o_icmp_last,
    output logic               o_icmp_valid,
    input  logic               i_icmp_ready,
    output logic               o_busy,
    output logic [P_CNT_W-1:0] o_drop_cnt
);
    localparam int          AW      = (P_MAX_PAYLOAD > 1) ? $clog2(P_MAX_PAYLOAD) : 1;
    localparam logic [15:0] MAX_LEN = 16'(8 + P_MAX_PAYLOAD);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RX   = 3'd1,
        S_DROP = 3'd2,
        S_CSUM = 3'd3,
        S_TX   = 3'd4
    } state_t;

    function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    state_t             state_q, state_d;
    logic [15:0]        idx_q, idx_d, len_q, len_d;
    logic [15:0]        rx_sum_q, rx_sum_d, tx_sum_q, tx_sum_d, cs_q, cs_d;
    logic [15:0]        tx_idx_q, tx_idx_d, olen_q, olen_d;
    logic [7:0]         hi_q, hi_d, data_q, data_d;
    logic [31:0]        hdr_q, hdr_d;
    logic               ign_q, ign_d, last_q, last_d, valid_q, valid_d, busy_q, busy_d;
    logic [P_CNT_W-1:0] cnt_q, cnt_d;

    logic [7:0]         mem [0:P_MAX_PAYLOAD-1];
    logic [7:0]         rd_q;
    logic               we_s;
    logic [AW-1:0]      ram_addr_s, wr_addr_s;

    logic [15:0]        byte_idx_s, word_s, base_rx_s, base_tx_s, rx_sum_nx_s, tx_sum_nx_s;
    logic [15:0]        nxt_s, rd_idx_s;
    logic [7:0]         nxt_byte_s;
    logic               add_s, bad_s, cnt_inc_s, ign_nx_s, rd_sel_s;

    // RX byte classification, running checksums and next TX byte selection.
    always_comb begin
        byte_idx_s  = (state_q == S_IDLE) ? 16'd0 : idx_q;
        word_s      = byte_idx_s[0] ? {hi_q, i_icmp_data} : {i_icmp_data, 8'h00};
        add_s       = byte_idx_s[0] | i_icmp_last;
        base_rx_s   = (state_q == S_IDLE) ? 16'd0 : rx_sum_q;
        base_tx_s   = (state_q == S_IDLE) ? 16'd0 : tx_sum_q;
        rx_sum_nx_s = add_s ? ones_add(base_rx_s, word_s) : base_rx_s;
        tx_sum_nx_s = (add_s && byte_idx_s >= 16'd4) ? ones_add(base_tx_s, word_s) : base_tx_s;
        bad_s = ((byte_idx_s == 16'd0) &&
                 (i_icmp_data != 8'h08 || i_icmp_len < 16'd8 || i_icmp_len > MAX_LEN)) ||
                ((byte_idx_s == 16'd1) && (i_icmp_data != 8'h00));
        nxt_s = tx_idx_q + 16'd1;
        if (nxt_s < 16'd2) begin
            nxt_byte_s = 8'h00;
        end else if (nxt_s == 16'd2) begin
            nxt_byte_s = cs_q[15:8];
        end else if (nxt_s == 16'd3) begin
            nxt_byte_s = cs_q[7:0];
        end else if (nxt_s < 16'd8) begin
            case (nxt_s[1:0])
                2'd0:    nxt_byte_s = hdr_q[31:24];
                2'd1:    nxt_byte_s = hdr_q[23:16];
                2'd2:    nxt_byte_s = hdr_q[15:8];
                default: nxt_byte_s = hdr_q[7:0];
            endcase
        end else begin
            nxt_byte_s = rd_q;
        end
    end

    // Next-state and output logic of the request/reply state machine.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        hi_d      = hi_q;
        rx_sum_d  = rx_sum_q;
        tx_sum_d  = tx_sum_q;
        hdr_d     = hdr_q;
        cs_d      = cs_q;
        tx_idx_d  = tx_idx_q;
        olen_d    = olen_q;
        data_d    = data_q;
        last_d    = last_q;
        valid_d   = valid_q;
        ign_d     = ign_q;
        cnt_inc_s = 1'b0;
        we_s      = 1'b0;
        wr_addr_s = '0;
        // A frame arriving while a reply is pending is tracked only to count it.
        if (i_icmp_valid) begin
            ign_nx_s = ~i_icmp_last;
        end else begin
            ign_nx_s = ign_q;
        end
        case (state_q)
            S_IDLE, S_RX: begin
                if (i_icmp_valid) begin
                    idx_d    = byte_idx_s + 16'd1;
                    hi_d     = i_icmp_data;
                    rx_sum_d = rx_sum_nx_s;
                    tx_sum_d = tx_sum_nx_s;
                    if (byte_idx_s == 16'd0) begin
                        len_d = i_icmp_len;
                    end else begin
                        len_d = len_q;
                    end
                    if (byte_idx_s >= 16'd4 && byte_idx_s < 16'd8) begin
                        hdr_d = {hdr_q[23:0], i_icmp_data};
                    end else begin
                        hdr_d = hdr_q;
                    end
                    if (byte_idx_s >= 16'd8) begin
                        we_s      = 1'b1;
                        wr_addr_s = AW'(byte_idx_s - 16'd8);
                    end else begin
                        we_s = 1'b0;
                    end
                    if (bad_s) begin
                        if (i_icmp_last) begin
                            cnt_inc_s = 1'b1;
                            state_d   = S_IDLE;
                        end else begin
                            state_d = S_DROP;
                        end
                    end else if (i_icmp_last) begin
                        if ((byte_idx_s + 16'd1 == i_icmp_len) && (rx_sum_nx_s == 16'hFFFF)) begin
                            state_d = S_CSUM;
                        end else begin
                            cnt_inc_s = 1'b1;
                            state_d   = S_IDLE;
                        end
                    end else if (byte_idx_s + 16'd1 == i_icmp_len) begin
                        state_d = S_DROP;
                    end else begin
                        state_d = S_RX;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_DROP: begin
                if (i_icmp_valid && i_icmp_last) begin
                    cnt_inc_s = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_DROP;
                end
            end
            S_CSUM: begin
                cs_d      = ~tx_sum_q;
                data_d    = 8'h00;
                valid_d   = 1'b1;
                last_d    = (len_q == 16'd1);
                tx_idx_d  = 16'd0;
                olen_d    = len_q;
                ign_d     = ign_nx_s;
                cnt_inc_s = i_icmp_valid & i_icmp_last;
                state_d   = S_TX;
            end
            S_TX: begin
                ign_d     = ign_nx_s;
                cnt_inc_s = i_icmp_valid & i_icmp_last;
                if (valid_q && i_icmp_ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        ign_d   = 1'b0;
                        state_d = ign_nx_s ? S_DROP : S_IDLE;
                    end else begin
                        tx_idx_d = nxt_s;
                        data_d   = nxt_byte_s;
                        last_d   = (nxt_s == olen_q - 16'd1);
                    end
                end else begin
                    state_d = S_TX;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Buffer read runs one byte ahead of the byte being presented.
        rd_idx_s   = tx_idx_d + 16'd1;
        rd_sel_s   = (state_q == S_CSUM || state_q == S_TX) && (rd_idx_s >= 16'd8) && (rd_idx_s < MAX_LEN);
        ram_addr_s = rd_sel_s ? AW'(rd_idx_s - 16'd8) : wr_addr_s;
        busy_d     = (state_d == S_RX) || (state_d == S_CSUM) || (state_d == S_TX);
        cnt_d      = (cnt_inc_s && (cnt_q != {P_CNT_W{1'b1}})) ? cnt_q + P_CNT_W'(1) : cnt_q;
    end

    // Payload buffer: single port with registered read.
    always_ff @(posedge i_clk) begin
        if (we_s) begin
            mem[ram_addr_s] <= i_icmp_data;
        end
        rd_q <= mem[ram_addr_s];
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= S_IDLE;
            idx_q    <= 16'd0;
            len_q    <= 16'd0;
            hi_q     <= 8'h00;
            rx_sum_q <= 16'd0;
            tx_sum_q <= 16'd0;
            hdr_q    <= 32'd0;
            cs_q     <= 16'd0;
            tx_idx_q <= 16'd0;
            olen_q   <= 16'd0;
            data_q   <= 8'h00;
            last_q   <= 1'b0;
            valid_q  <= 1'b0;
            ign_q    <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            hi_q     <= hi_d;
            rx_sum_q <= rx_sum_d;
            tx_sum_q <= tx_sum_d;
            hdr_q    <= hdr_d;
            cs_q     <= cs_d;
            tx_idx_q <= tx_idx_d;
            olen_q   <= olen_d;
            data_q   <= data_d;
            last_q   <= last_d;
            valid_q  <= valid_d;
            ign_q    <= ign_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_icmp_data  = data_q;
    assign o_icmp_len   = olen_q;
    assign o_icmp_last  = last_q;
    assign o_icmp_valid = valid_q;
    assign o_busy       = busy_q;
    assign o_drop_cnt   = cnt_q;

endmodule

// File: tb/tb_icmp_echo_engine.sv
// Directed self-checking bench for icmp_echo_engine.
module tb_icmp_echo_engine;
    localparam int P_MAX = 64;
    localparam logic [95:0] REQ12 = 96'h0800_3337_0001_0001_6162_6364;
    localparam logic [95:0] REP12 = 96'h0000_3B37_0001_0001_6162_6364;
    localparam logic [95:0] REQ11 = 96'h0800_339B_0001_0001_6162_6300;
    localparam logic [95:0] REP11 = 96'h0000_3B9B_0001_0001_6162_6300;
    localparam logic [95:0] BADCS = 96'h0800_3338_0001_0001_6162_6364;
    localparam logic [95:0] TYPE0 = 96'h0000_3337_0001_0001_6162_6364;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  din = 8'h00;
    logic [15:0] ilen = 16'd0;
    logic        ilast = 1'b0, ivalid = 1'b0, ready = 1'b1;
    logic [7:0]  o_data;
    logic [15:0] o_len;
    logic        o_last, o_valid, o_busy;
    logic [15:0] o_drop;

    icmp_echo_engine #(.P_MAX_PAYLOAD(P_MAX), .P_CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst_n),
        .i_icmp_data(din), .i_icmp_len(ilen), .i_icmp_last(ilast), .i_icmp_valid(ivalid),
        .o_icmp_data(o_data), .o_icmp_len(o_len), .o_icmp_last(o_last), .o_icmp_valid(o_valid),
        .i_icmp_ready(ready), .o_busy(o_busy), .o_drop_cnt(o_drop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;
    int exp_drop = 0;
    int rx_last_cyc = 0;
    logic [7:0] frm [0:11];
    logic [7:0] exp_b [0:11];

    // Reply monitor: records handshakes and flags outputs that move while stalled.
    logic [7:0]  got_data [$];
    logic        got_last [$];
    logic [15:0] got_len [$];
    int          got_cyc [$];
    int          vrise_cyc [$];
    int          hold_err = 0;
    logic        prev_stall = 1'b0, prev_valid = 1'b0;
    logic [7:0]  p_data = 8'h00;
    logic        p_last = 1'b0;
    logic [15:0] p_len = 16'd0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
            prev_valid <= 1'b0;
        end else begin
            if (prev_stall && !(o_valid === 1'b1 && o_data === p_data && o_last === p_last && o_len === p_len))
                hold_err <= hold_err + 1;
            if (o_valid && !prev_valid) vrise_cyc.push_back(cyc);
            if (o_valid && ready) begin
                got_data.push_back(o_data);
                got_last.push_back(o_last);
                got_len.push_back(o_len);
                got_cyc.push_back(cyc);
            end
            prev_stall <= o_valid & ~ready;
            prev_valid <= o_valid;
            p_data <= o_data;
            p_last <= o_last;
            p_len <= o_len;
        end
    end

    task automatic load(input logic [95:0] req, input logic [95:0] rep);
        for (int i = 0; i < 12; i++) begin
            frm[i]   = req[95-8*i -: 8];
            exp_b[i] = rep[95-8*i -: 8];
        end
    endtask

    task automatic send_frame(input int n, input logic [15:0] len);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            din = frm[i]; ilen = len; ivalid = 1'b1; ilast = (i == n - 1);
            if (i == n - 1) rx_last_cyc = cyc;
        end
        @(posedge clk); #1;
        ivalid = 1'b0; ilast = 1'b0; din = 8'h00;
    endtask

    task automatic wait_bytes(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (got_data.size() >= target) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_data, o_len, o_last, o_valid, o_busy, o_drop} !== 43'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %0h, expected 0", {o_data, o_len, o_last, o_valid, o_busy, o_drop});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got valid=%0b busy=%0b, expected 0 0", o_valid, o_busy);
        end
    endtask

    task automatic test_basic(input int n, input logic [95:0] req, input logic [95:0] rep);
        int base, vb;
        bit ok;
        base = got_data.size();
        vb = vrise_cyc.size();
        load(req, rep);
        ready = 1'b1;
        send_frame(n, 16'(n));
        n_checks++;
        if (o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_len%0d: got %0b, expected 1", n, o_busy);
        end
        wait_bytes(base + n, ok);
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (!ok || got_data.size() != base + n) begin
            n_fail++;
            $display("FAIL count_len%0d: got %0d bytes, expected %0d", n, got_data.size() - base, n);
        end else begin
            for (int i = 0; i < n; i++) begin
                n_checks++;
                if (got_data[base+i] !== exp_b[i] || got_last[base+i] !== (i == n - 1)) begin
                    n_fail++;
                    $display("FAIL byte_len%0d[%0d]: got %0h last=%0b, expected %0h last=%0b",
                             n, i, got_data[base+i], got_last[base+i], exp_b[i], (i == n - 1));
                end
            end
            n_checks++;
            if (got_len[base] !== 16'(n)) begin
                n_fail++;
                $display("FAIL len_len%0d: got %0d, expected %0d", n, got_len[base], n);
            end
            n_checks++;
            if (got_cyc[base+n-1] - got_cyc[base] != n - 1) begin
                n_fail++;
                $display("FAIL contiguous_len%0d: got span %0d, expected %0d", n, got_cyc[base+n-1] - got_cyc[base], n - 1);
            end
        end
        n_checks++;
        if (vrise_cyc.size() <= vb || vrise_cyc[vb] != rx_last_cyc + 2) begin
            n_fail++;
            $display("FAIL latency_len%0d: got first valid cycle %0d, expected %0d", n,
                     (vrise_cyc.size() > vb) ? vrise_cyc[vb] : -1, rx_last_cyc + 2);
        end
        n_checks++;
        if (o_drop !== 16'(exp_drop) || o_busy !== 1'b0 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL end_state_len%0d: got drop=%0d busy=%0b valid=%0b, expected %0d 0 0",
                     n, o_drop, o_busy, o_valid, exp_drop);
        end
    endtask

    task automatic test_backpressure();
        int base, herr;
        logic [3:0] pat;
        pat = 4'b1001;
        base = got_data.size();
        herr = hold_err;
        load(REQ12, REP12);
        ready = 1'b1;
        send_frame(12, 16'd12);
        for (int i = 0; i < 300 && got_data.size() < base + 12; i++) begin
            @(posedge clk); #1;
            ready = pat[3 - (i % 4)];
        end
        ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (got_data.size() != base + 12) begin
            n_fail++;
            $display("FAIL bp_count: got %0d bytes, expected 12", got_data.size() - base);
        end else begin
            for (int i = 0; i < 12; i++) begin
                n_checks++;
                if (got_data[base+i] !== exp_b[i] || got_last[base+i] !== (i == 11)) begin
                    n_fail++;
                    $display("FAIL bp_byte[%0d]: got %0h last=%0b, expected %0h last=%0b",
                             i, got_data[base+i], got_last[base+i], exp_b[i], (i == 11));
                end
            end
        end
        n_checks++;
        if (hold_err != herr) begin
            n_fail++;
            $display("FAIL bp_hold: got %0d unstable stalls, expected 0", hold_err - herr);
        end
    endtask

    task automatic test_drops();
        logic [95:0] reqs [0:2];
        logic [15:0] lens [0:2];
        int base;
        reqs[0] = BADCS; lens[0] = 16'd12;
        reqs[1] = TYPE0; lens[1] = 16'd12;
        reqs[2] = REQ12; lens[2] = 16'(8 + P_MAX + 1);
        ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            base = got_data.size();
            load(reqs[k], REP12);
            send_frame(12, lens[k]);
            exp_drop++;
            n_checks++;
            if (o_drop !== 16'(exp_drop)) begin
                n_fail++;
                $display("FAIL drop_cnt[%0d]: got %0d, expected %0d", k, o_drop, exp_drop);
            end
            repeat (15) @(posedge clk);
            #1;
            n_checks++;
            if (got_data.size() != base) begin
                n_fail++;
                $display("FAIL drop_noreply[%0d]: got %0d bytes, expected 0", k, got_data.size() - base);
            end
        end
    endtask

    task automatic test_back_to_back();
        int base, vb;
        bit found, ok;
        base = got_data.size();
        vb = vrise_cyc.size();
        load(REQ12, REP12);
        ready = 1'b1;
        send_frame(12, 16'd12);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (vrise_cyc.size() > vb) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL b2b_start: got no reply start, expected one");
        end
        send_frame(12, 16'd12);
        exp_drop++;
        wait_bytes(base + 12, ok);
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (got_data.size() != base + 12) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d bytes, expected 12", got_data.size() - base);
        end else begin
            for (int i = 0; i < 12; i++) begin
                n_checks++;
                if (got_data[base+i] !== exp_b[i]) begin
                    n_fail++;
                    $display("FAIL b2b_byte[%0d]: got %0h, expected %0h", i, got_data[base+i], exp_b[i]);
                end
            end
        end
        n_checks++;
        if (o_drop !== 16'(exp_drop)) begin
            n_fail++;
            $display("FAIL b2b_drop: got %0d, expected %0d", o_drop, exp_drop);
        end
    endtask

    task automatic test_reset_mid_tx();
        int base;
        bit ok;
        base = got_data.size();
        load(REQ12, REP12);
        ready = 1'b1;
        send_frame(12, 16'd12);
        wait_bytes(base + 4, ok);
        #2 rst_n = 1'b0;
        #1;
        exp_drop = 0;
        n_checks++;
        if (!ok || {o_data, o_len, o_last, o_valid, o_busy, o_drop} !== 43'd0) begin
            n_fail++;
            $display("FAIL midtx_reset_outputs: got %0h, expected 0", {o_data, o_len, o_last, o_valid, o_busy, o_drop});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (got_data.size() != base + 4 || got_last[got_data.size()-1] !== 1'b0) begin
            n_fail++;
            $display("FAIL midtx_abort: got %0d bytes, expected 4 with no last", got_data.size() - base);
        end
        test_basic(11, REQ11, REP11);
    endtask

    initial begin
        test_reset();
        test_basic(12, REQ12, REP12);
        test_basic(11, REQ11, REP11);
        test_backpressure();
        test_drops();
        test_back_to_back();
        test_reset_mid_tx();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/icmp_echo_engine.md
# icmp_echo_engine

Parametrised ICMP echo responder that sits between the IP layer's ICMP receive/transmit byte streams. It buffers a complete Echo Request, verifies its checksum, and emits a matching Echo Reply with the identifier, sequence and payload echoed and the checksum recomputed. Unlike the earlier trigger-only responder, it echoes the full payload, honours transmit backpressure, and reports dropped requests.

## Interface
- P_MAX_PAYLOAD, 64: maximum echo payload bytes buffered; range 1..1472.
- P_CNT_W, 16: width of the drop counter.
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-low reset.
- i_icmp_data  in  8  RX ICMP byte, starting at the type field.
- i_icmp_len  in  16  RX ICMP length in bytes (header + payload); stable while valid.
- i_icmp_last  in  1  RX final byte.
- i_icmp_valid  in  1  RX byte strobe; no backpressure.
- o_icmp_data  out  8  TX reply byte.
- o_icmp_len  out  16  TX reply length; equals the request length.
- o_icmp_last  out  1  TX final byte.
- o_icmp_valid  out  1  TX byte valid.
- i_icmp_ready  in  1  TX sink accepts the byte when valid && ready.
- o_busy  out  1  high from the first RX byte of an accepted request until the TX last handshake.
- o_drop_cnt  out  P_CNT_W  count of dropped requests; saturates at all-ones.

## Operation
- States: IDLE, RX, DROP, CSUM, TX.
- IDLE: on valid, go to RX (or to DROP if o_busy would block). The byte at index 0 is captured.
- RX: a byte index counter runs from 0.
  - Bytes 0 and 1 must be 0x08 and 0x00.
  - Bytes 4..7 (identifier, sequence) go to header registers.
  - Bytes 8.. go to the payload buffer at address index-8.
- Length checks:
  - i_icmp_len below 8 or above 8+P_MAX_PAYLOAD → DROP at the first byte.
  - Wrong type or code → DROP.
- Checksum accumulators:
  - A 17-bit running one's-complement sum covers all 16-bit big-endian words, with end-around carry folded every word.
  - Odd length: the final byte is padded with 0x00 in the low half.
  - Two sums are kept:
    - rx_sum: all words, including type/code and checksum.
    - tx_sum: words from index 4 onward only. The reply's type/code word is 0x0000 and its checksum field is treated as zero.
- Last byte in RX:
  - Request is accepted if index+1 == i_icmp_len and rx_sum == 0xFFFF. Go to CSUM.
  - Otherwise the request is dropped: increment o_drop_cnt, go to IDLE.
- Missing last: if index reaches i_icmp_len-1 without last, the request is dropped and the engine waits in DROP.
- DROP: ignore bytes until last, increment o_drop_cnt once, go to IDLE.
- CSUM: reply checksum = ~tx_sum (16 bits). Go to TX.
- TX: emits bytes in this order, advancing only on valid && ready:
  - 0x00, 0x00
  - checksum high, checksum low
  - identifier, sequence
  - payload bytes from the buffer
  - o_icmp_last is asserted on byte o_icmp_len-1.
  - After the last handshake, go to IDLE.
- Requests arriving during CSUM/TX are not buffered. Their bytes are ignored and each is counted as one drop at its last byte.

## Timing
- Reset (i_rst low, asynchronous): the state machine returns to IDLE immediately. The following outputs reset to 0:
  - o_icmp_data, o_icmp_len, o_icmp_last, o_icmp_valid
  - o_busy, o_drop_cnt
  - all counters and sums.
  - Buffer contents are don't-care.
- Reset mid-TX aborts the reply. No partial last is ever generated.
- Latency: RX last in cycle N → CSUM in N+1 → o_icmp_valid high with byte 0 in N+2.
- o_icmp_valid stays high until the last handshake. Data, last and len are held stable while ready is low.
- With ready held high, the reply is contiguous, len cycles long.
- Drop counter update: registered, the cycle after the RX last of a dropped frame.
- An RX last in the same cycle as the TX last handshake is counted as a drop. The engine is IDLE only from the next cycle.
- Payload buffer is single-port, read one cycle ahead. The TX read address is prefetched so it is never a bubble source.

## Test plan
- Request with length 12: bytes 08 00 33 37 00 01 00 01 61 62 63 64, ready=1. Required reply: 00 00 3B 37 00 01 00 01 61 62 63 64, len=12, first valid 2 cycles after RX last, last on byte 12, drop_cnt=0.
- Odd request with length 11: bytes 08 00 33 9B 00 01 00 01 61 62 63. Required reply: 00 00 3B 9B 00 01 00 01 61 62 63.
- Same 12-byte request with ready toggling 1,0,0,1 repeatedly → byte sequence unchanged, with no byte duplicated or skipped.
- Rejected requests → no reply and drop_cnt increments by 1 each:
  - corrupted checksum (33 38);
  - type 0x00;
  - len = 8+P_MAX_PAYLOAD+1.
- Second valid request starting during TX of the first → first reply is intact, second produces no reply, drop_cnt=1.
- Assert i_rst low mid-TX, then release, then send a fresh request → all outputs 0 during reset, and the fresh request gives a correct full reply.
